pc_stack: RTL and testbench

Parametrised program counter with a hardware return-address stack, the successor to the single-register PC. Holds the fetch address for the instruction ROM and applies one control-flow operation per cycle: sequential advance, conditional relative or absolute branch, conditional call (push return address) or conditional return (pop). Sits between the decoder/flag logic and instruction memory, and adds stall, stack status and an optional overflow/underflow guard.

---
 rtl/pc_pkg.sv | 15 +
 rtl/ret_stack.sv | 91 +++++++++
 rtl/pc_stack.sv | 75 +++++++
 tb/tb_pc_stack.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default sizes for the program counter and its return stack.
package pc_pkg;

   localparam int PC_D_DEF     = 12;
   localparam int PC_DEPTH_DEF = 8;

   typedef enum logic [2:0] {
      PC_NEXT  = 3'd0,
      PC_BRREL = 3'd1,
      PC_BRABS = 3'd2,
      PC_CALL  = 3'd3,
      PC_RET   = 3'd4
   } pc_op_t;

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack with depth tracking.
// Define PC_STACK_GUARD_EN to suppress overflow/underflow and raise a sticky err.
module ret_stack
   import pc_pkg::*;
#(
   parameter int D     = PC_D_DEF,
   parameter int DEPTH = PC_DEPTH_DEF,
   localparam int SPW  = $clog2(DEPTH),
   localparam int DW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [D-1:0]  wdata_i,
   output logic          push_ok_o,
   output logic          pop_ok_o,
   output logic [D-1:0]  pop_data_o,
   output logic [D-1:0]  top_o,
   output logic [DW-1:0] depth_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          err_o
);

   localparam logic [SPW-1:0] SP_MAX    = SPW'(DEPTH - 1);
   localparam logic [DW-1:0]  DEPTH_MAX = DW'(DEPTH);

   logic [D-1:0]   mem_q [DEPTH];
   logic [SPW-1:0] sp_q, sp_d, sp_inc, sp_dec;
   logic [DW-1:0]  depth_q, depth_d;
   logic           full, empty;

   // sp wraps explicitly because DEPTH need not be a power of two.
   assign sp_inc = (sp_q == SP_MAX) ? '0 : sp_q + SPW'(1);
   assign sp_dec = (sp_q == '0) ? SP_MAX : sp_q - SPW'(1);
   assign full   = (depth_q == DEPTH_MAX);
   assign empty  = (depth_q == '0);

`ifdef PC_STACK_GUARD_EN
   logic err_q;

   assign push_ok_o = push_i & ~full;
   assign pop_ok_o  = pop_i & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_q | (push_i & full) | (pop_i & empty);
   end

   assign err_o = err_q;
`else
   assign push_ok_o = push_i;
   assign pop_ok_o  = pop_i;
   assign err_o     = 1'b0;
`endif

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
      sp_d    = sp_q;
      depth_d = depth_q;
      if (push_ok_o) begin
         sp_d = sp_inc;
         if (!full) depth_d = depth_q + DW'(1);
      end else if (pop_ok_o) begin
         sp_d = sp_dec;
         if (!empty) depth_d = depth_q - DW'(1);
      end
   end

   // NOTE: stack storage is reset because a fresh stack must read back as all-zero entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q    <= '0;
         depth_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
         sp_q    <= sp_d;
         depth_q <= depth_d;
         if (push_ok_o) mem_q[sp_q] <= wdata_i;
      end
   end

   assign pop_data_o = mem_q[sp_dec];
   assign top_o      = empty ? '0 : mem_q[sp_dec];
   assign depth_o    = depth_q;
   assign full_o     = full;
   assign empty_o    = empty;

endmodule

// File: rtl/pc_stack.sv
// Program counter with conditional branch/call/return and a hardware return stack.
// Optional overflow/underflow guard enabled by defining PC_STACK_GUARD_EN.
module pc_stack
   import pc_pkg::*;
#(
   parameter int             D         = PC_D_DEF,
   parameter int             DEPTH     = PC_DEPTH_DEF,
   parameter logic [D-1:0]   RESET_VEC = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic [2:0]                   op,
   input  logic                         flag,
   input  logic                         invert,
   input  logic [D-1:0]                 target,
   output logic [D-1:0]                 prog_ctr,
   output logic [D-1:0]                 ret_addr,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         stack_full,
   output logic                         stack_empty,
   output logic                         err
);

   pc_op_t       op_e;
   logic         cond;
   logic         push_req, pop_req, push_ok, pop_ok;
   logic [D-1:0] pc_q, pc_d, pc_plus1, pop_data;

   assign op_e     = pc_op_t'(op);
   assign cond     = flag ^ invert;
   assign pc_plus1 = pc_q + D'(1);
   assign push_req = ~stall & cond & (op_e == PC_CALL);
   assign pop_req  = ~stall & cond & (op_e == PC_RET);

   ret_stack #(
      .D     (D),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk        (clk),
      .rst_n      (reset),
      .push_i     (push_req),
      .pop_i      (pop_req),
      .wdata_i    (pc_plus1),
      .push_ok_o  (push_ok),
      .pop_ok_o   (pop_ok),
      .pop_data_o (pop_data),
      .top_o      (ret_addr),
      .depth_o    (depth),
      .full_o     (stack_full),
      .empty_o    (stack_empty),
      .err_o      (err)
   );

   // A suppressed (guarded) call or return falls through to pc+1.
   always_comb begin
      pc_d = pc_plus1;
      case (op_e)
         PC_BRREL: if (cond)    pc_d = pc_q + target;
         PC_BRABS: if (cond)    pc_d = target;
         PC_CALL:  if (push_ok) pc_d = target;
         PC_RET:   if (pop_ok)  pc_d = pop_data;
         default:               pc_d = pc_plus1;
      endcase
      if (stall) pc_d = pc_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc_q <= RESET_VEC;
      else        pc_q <= pc_d;
   end

   assign prog_ctr = pc_q;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: stimulus queues expected state, a negedge monitor compares.
// Expectations follow PC_STACK_GUARD_EN when defined.
module tb_pc_stack;

   localparam int D     = 12;
   localparam int DEPTH = 8;

   localparam logic [2:0] OP_NEXT  = 3'd0;
   localparam logic [2:0] OP_BRREL = 3'd1;
   localparam logic [2:0] OP_BRABS = 3'd2;
   localparam logic [2:0] OP_CALL  = 3'd3;
   localparam logic [2:0] OP_RET   = 3'd4;

   typedef struct packed {
      logic [11:0] pc;
      logic [3:0]  dep;
      logic [11:0] ret;
      logic        full;
      logic        empty;
      logic        err;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [2:0]  op;
   logic        flag;
   logic        invert;
   logic [11:0] target;
   logic [11:0] prog_ctr;
   logic [11:0] ret_addr;
   logic [3:0]  depth;
   logic        stack_full;
   logic        stack_empty;
   logic        err;

   obs_t  exp_q[$];
   string name_q[$];
   int    total = 0;
   int    bad   = 0;
   logic  exp_err = 1'b0;

   logic [11:0] cur;
   logic [11:0] pushed [9];

   pc_stack #(
      .D         (D),
      .DEPTH     (DEPTH),
      .RESET_VEC (12'h000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .op          (op),
      .flag        (flag),
      .invert      (invert),
      .target      (target),
      .prog_ctr    (prog_ctr),
      .ret_addr    (ret_addr),
      .depth       (depth),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .err         (err)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [11:0] pc, input logic [3:0] dep,
                               input logic [11:0] ret, input logic e);
      obs_t o;
      o.pc    = pc;
      o.dep   = dep;
      o.ret   = ret;
      o.full  = (dep == 4'd8);
      o.empty = (dep == 4'd0);
      o.err   = e;
      return o;
   endfunction

   task automatic expect_now(input string nm, input logic [11:0] pc,
                             input logic [3:0] dep, input logic [11:0] ret);
      exp_q.push_back(mk(pc, dep, ret, exp_err));
      name_q.push_back(nm);
   endtask

   task automatic step(input logic [2:0] o, input logic f, input logic inv,
                       input logic [11:0] tgt, input string nm,
                       input logic [11:0] pc, input logic [3:0] dep,
                       input logic [11:0] ret);
      op     = o;
      flag   = f;
      invert = inv;
      target = tgt;
      @(posedge clk);
      #1;
      expect_now(nm, pc, dep, ret);
   endtask

   // Monitor: one observation per cycle, compared mid-period.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         obs_t  e, a;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = '{pc: prog_ctr, dep: depth, ret: ret_addr, full: stack_full,
                empty: stack_empty, err: err};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL %s: got pc=%h depth=%0d ret=%h full=%b empty=%b err=%b, want pc=%h depth=%0d ret=%h full=%b empty=%b err=%b",
                     nm, a.pc, a.dep, a.ret, a.full, a.empty, a.err,
                     e.pc, e.dep, e.ret, e.full, e.empty, e.err);
         end
      end
   end

   initial begin
      reset  = 1'b0;
      stall  = 1'b0;
      op     = OP_BRABS;
      flag   = 1'b1;
      invert = 1'b0;
      target = 12'h123;

      // Reset held: BRABS must not take effect.
      step(OP_BRABS, 1, 0, 12'h123, "rst_hold0", 12'h000, 0, 12'h000);
      step(OP_BRABS, 1, 0, 12'h123, "rst_hold1", 12'h000, 0, 12'h000);
      reset = 1'b1;
      step(OP_NEXT, 0, 0, 12'h000, "next1", 12'h001, 0, 12'h000);
      step(OP_NEXT, 0, 0, 12'h000, "next2", 12'h002, 0, 12'h000);
      step(OP_NEXT, 0, 0, 12'h000, "next3", 12'h003, 0, 12'h000);

      // Branches.
      step(OP_BRABS, 1, 0, 12'h010, "brabs_to_010", 12'h010, 0, 12'h000);
      step(OP_BRREL, 1, 0, 12'hFFC, "brrel_m4",     12'h00C, 0, 12'h000);
      step(OP_BRABS, 1, 1, 12'h200, "brabs_inv_nt", 12'h00D, 0, 12'h000);
      step(OP_BRREL, 0, 0, 12'h005, "brrel_nt",     12'h00E, 0, 12'h000);
      step(OP_BRREL, 0, 1, 12'h010, "brrel_inv_t",  12'h01E, 0, 12'h000);
      step(3'd6,     1, 0, 12'h300, "undef_op6",    12'h01F, 0, 12'h000);
      step(3'd7,     1, 0, 12'h300, "undef_op7",    12'h020, 0, 12'h000);
      step(OP_BRABS, 1, 0, 12'hFFF, "brabs_fff",    12'hFFF, 0, 12'h000);
      step(OP_NEXT,  0, 0, 12'h000, "pc_wrap",      12'h000, 0, 12'h000);

      // Call / return.
      step(OP_BRABS, 1, 0, 12'h040, "to_040",    12'h040, 0, 12'h000);
      step(OP_CALL,  1, 0, 12'h300, "call_300",  12'h300, 1, 12'h041);
      step(OP_NEXT,  0, 0, 12'h000, "in_sub1",   12'h301, 1, 12'h041);
      step(OP_NEXT,  0, 0, 12'h000, "in_sub2",   12'h302, 1, 12'h041);
      step(OP_RET,   1, 0, 12'h000, "ret_041",   12'h041, 0, 12'h000);
      step(OP_CALL,  0, 0, 12'h300, "call_nt",   12'h042, 0, 12'h000);
      step(OP_RET,   1, 1, 12'h000, "ret_nt",    12'h043, 0, 12'h000);

      // Stall holds everything, then the held CALL goes through.
      step(OP_BRABS, 1, 0, 12'h050, "to_050", 12'h050, 0, 12'h000);
      stall = 1'b1;
      step(OP_CALL, 1, 0, 12'h400, "stall_call0", 12'h050, 0, 12'h000);
      step(OP_CALL, 1, 0, 12'h400, "stall_call1", 12'h050, 0, 12'h000);
      stall = 1'b0;
      step(OP_CALL, 1, 0, 12'h400, "unstall_call", 12'h400, 1, 12'h051);
      step(OP_RET,  1, 0, 12'h000, "unstall_ret",  12'h051, 0, 12'h000);
      cur = 12'h051;

      // Nesting to full.
      for (int i = 0; i < 8; i++) begin
         logic [11:0] tgt;
         tgt       = 12'h100 + 12'(16 * i);
         pushed[i] = cur + 12'h001;
         step(OP_CALL, 1, 0, tgt, "nest_call", tgt, 4'(i + 1), cur + 12'h001);
         cur = tgt;
      end

`ifdef PC_STACK_GUARD_EN
      exp_err = 1'b1;
      step(OP_CALL, 1, 0, 12'h500, "ovf_call", cur + 12'h001, 8, pushed[7]);
      cur = cur + 12'h001;
      for (int k = 0; k < 8; k++) begin
         int top;
         top = 7 - k;
         step(OP_RET, 1, 0, 12'h000, "nest_ret", pushed[top], 4'(7 - k),
              (k < 7) ? pushed[top - 1] : 12'h000);
         cur = pushed[top];
      end
      step(OP_RET, 1, 0, 12'h000, "udf_ret", cur + 12'h001, 0, 12'h000);
      cur = cur + 12'h001;
`else
      pushed[8] = cur + 12'h001;
      step(OP_CALL, 1, 0, 12'h500, "ovf_call", 12'h500, 8, cur + 12'h001);
      cur = 12'h500;
      for (int k = 0; k < 8; k++) begin
         int top;
         top = 8 - k;
         step(OP_RET, 1, 0, 12'h000, "nest_ret", pushed[top], 4'(7 - k),
              (k < 7) ? pushed[top - 1] : 12'h000);
         cur = pushed[top];
      end
      // Unguarded underflow reads the wrapped slot, last written by the overflow push.
      step(OP_RET, 1, 0, 12'h000, "udf_ret", pushed[8], 0, 12'h000);
      cur = pushed[8];
`endif

      // Back-to-back CALL then RET.
      step(OP_CALL, 1, 0, 12'h600, "b2b_call", 12'h600, 1, cur + 12'h001);
      step(OP_RET,  1, 0, 12'h000, "b2b_ret",  cur + 12'h001, 0, 12'h000);

      // Asynchronous reset in the middle of a pending CALL.
      step(OP_CALL, 1, 0, 12'h700, "pre_rst_call", 12'h700, 1, cur + 12'h002);
      @(negedge clk);
      #2;
      reset   = 1'b0;
      exp_err = 1'b0;
      #1;
      expect_now("async_rst", 12'h000, 0, 12'h000);
      @(negedge clk);
      #1;
      reset = 1'b1;
      step(OP_NEXT, 0, 0, 12'h000, "post_rst_next", 12'h001, 0, 12'h000);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d observations left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
